// File: rtl/axi_lite_mem_responder.sv
// rtl/axi_lite_mem_responder.sv - AXI4-Lite responder backed by a byte-strobed word RAM
// Optional feature macro: AXI_MEM_RANGE_CHECK_EN (DECERR outside [BASE_ADDR, BASE_ADDR + 4*2**ADDR_WIDTH))
module axi_lite_mem_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] axi_araddr,
  output logic        axi_arready,
  input  logic        axi_arvalid,
  output logic [31:0] axi_rdata,
  input  logic        axi_rready,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic [31:0] axi_awaddr,
  output logic        axi_awready,
  input  logic        axi_awvalid,
  input  logic [31:0] axi_wdata,
  output logic        axi_wready,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  input  logic        axi_bready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {R_IDLE, R_MEM, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH];

  r_state_t              r_state;
  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  rd_err;
  logic                  wr_err;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  aw_got;
  logic                  w_got;
  logic                  ar_bad;
  logic                  aw_bad;
  logic                  ar_hs;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  aw_done;
  logic                  w_done;

`ifdef AXI_MEM_RANGE_CHECK_EN
  // Offsets are computed one bit wider so an address below the base wraps to a huge value.
  localparam logic [32:0] WINDOW_BYTES = 33'd1 << (ADDR_WIDTH + 2);
  logic [32:0] ar_off;
  logic [32:0] aw_off;
  assign ar_off = {1'b0, axi_araddr} - {1'b0, BASE_ADDR};
  assign aw_off = {1'b0, axi_awaddr} - {1'b0, BASE_ADDR};
  assign ar_bad = (ar_off >= WINDOW_BYTES);
  assign aw_bad = (aw_off >= WINDOW_BYTES);
`else
  // Without the check, upper address bits simply alias onto the RAM.
  assign ar_bad = 1'b0;
  assign aw_bad = 1'b0;
`endif

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi_araddr, axi_awaddr, BASE_ADDR};

  assign ar_hs   = axi_arvalid && axi_arready;
  assign aw_hs   = axi_awvalid && axi_awready;
  assign w_hs    = axi_wvalid && axi_wready;
  assign aw_done = aw_got || aw_hs;
  assign w_done  = w_got || w_hs;

  // Read FSM: accept one address, read the RAM a cycle later, hold the response until taken.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= R_IDLE;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= 32'h0;
      axi_rresp   <= 2'b00;
      rd_idx      <= '0;
      rd_err      <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_idx      <= axi_araddr[ADDR_WIDTH+1:2];
            rd_err      <= ar_bad;
            axi_arready <= 1'b0;
            r_state     <= R_MEM;
          end else begin
            axi_arready <= 1'b1;
          end
        end
        R_MEM: begin
          axi_rvalid <= 1'b1;
          axi_rdata  <= rd_err ? 32'h0 : mem[rd_idx];
          axi_rresp  <= rd_err ? 2'b11 : 2'b00;
          r_state    <= R_RESP;
        end
        R_RESP: begin
          if (axi_rready) begin
            axi_rvalid  <= 1'b0;
            axi_arready <= 1'b1;
            r_state     <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: collect AW and W in any order, commit once, hold the response until taken.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state     <= W_IDLE;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= 2'b00;
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      wr_idx      <= '0;
      wr_err      <= 1'b0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            wr_idx <= axi_awaddr[ADDR_WIDTH+1:2];
            wr_err <= aw_bad;
          end
          if (w_hs) begin
            wdata_q <= axi_wdata;
            wstrb_q <= axi_wstrb;
          end
          axi_awready <= !aw_done;
          axi_wready  <= !w_done;
          if (aw_done && w_done) begin
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            w_state <= W_COMMIT;
          end else begin
            aw_got <= aw_done;
            w_got  <= w_done;
          end
        end
        W_COMMIT: begin
          axi_bvalid <= 1'b1;
          axi_bresp  <= wr_err ? 2'b11 : 2'b00;
          w_state    <= W_RESP;
        end
        W_RESP: begin
          if (axi_bready) begin
            axi_bvalid  <= 1'b0;
            axi_awready <= 1'b1;
            axi_wready  <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // RAM write port: byte-lane update during commit; a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (rstn && (w_state == W_COMMIT) && !wr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
